avg_filter_param: RTL and testbench

AVG_FILTER_PARAM -- requirements
Module: avg_filter_param

---
 rtl/avg_filter_param.sv | 259 +++++++++++++++++++++++++
 tb/tb_avg_filter_param.sv | 292 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/avg_filter_param.sv
// 3x3 sliding-window image filter (bypass / rounded mean / min / max) over a raster stream.
// Latency: fixed 4 clk from an accepted pixel to its result, in every mode.
// Backpressure: none; one pixel per cycle, gaps in pre_img_valid simply pause the window.
//
// Ports:
//   clk, rst_n                    clock and async active-low reset
//   pre_img_vsync/hsync/valid     input sidebands; vsync rising edge starts a frame
//   pre_img_data [DATA_W]         input pixel
//   filt_mode [2], edge_mode      operation and border select, latched at frame start
//   post_img_vsync/hsync/valid    input sidebands delayed by 4 cycles
//   post_img_data [DATA_W]        filtered pixel (meaningful only while post_img_valid)
module avg_filter_param #(
    parameter int DATA_W = 8,
    parameter int IMG_W  = 640,
    parameter int IMG_H  = 480
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              pre_img_vsync,
    input  logic              pre_img_hsync,
    input  logic              pre_img_valid,
    input  logic [DATA_W-1:0] pre_img_data,
    input  logic [1:0]        filt_mode,
    input  logic              edge_mode,
    output logic              post_img_vsync,
    output logic              post_img_hsync,
    output logic              post_img_valid,
    output logic [DATA_W-1:0] post_img_data
);

    localparam int CW = $clog2(IMG_W);
    localparam int RW = $clog2(IMG_H);
    localparam int SW = DATA_W + 4;      // 9 * max pixel fits without overflow
    localparam int SH = SW + 4;          // shift wide enough for an exact reciprocal of 9
    localparam int PW = SW + SH;
    localparam logic [PW-1:0] DIV9_MUL = PW'((2**SH + 8) / 9);

    typedef enum logic [1:0] {
        MODE_BYPASS = 2'd0,
        MODE_MEAN   = 2'd1,
        MODE_MIN    = 2'd2,
        MODE_MAX    = 2'd3
    } mode_e;

    // Frame control state
    logic          vsync_q, vsync_d;
    logic          armed_q, armed_d;
    logic [CW-1:0] col_q, col_d;
    logic [RW-1:0] row_q, row_d;
    mode_e         mode_q, mode_d;
    logic          edge_q, edge_d;

    logic          vs_rise;
    logic          accept;
    logic [CW-1:0] col_cur;
    logic [RW-1:0] row_cur;
    mode_e         mode_cur;
    logic          edge_cur;

    // Line buffers: lb1 holds row r-1, lb2 holds row r-2
    logic [DATA_W-1:0] lb1_mem [IMG_W];
    logic [DATA_W-1:0] lb2_mem [IMG_W];
    logic [DATA_W-1:0] lb1_rd, lb2_rd;

    // Stage 1: window (index row*3+col, row 0 = r-2, col 2 = newest) plus pixel attributes
    logic [DATA_W-1:0] win_q [9];
    logic [DATA_W-1:0] win_d [9];
    logic              s1_vld_q, s1_vld_d;
    logic              s1_border_q, s1_border_d;
    mode_e             s1_mode_q, s1_mode_d;
    logic              s1_edge_q, s1_edge_d;

    // Stage 2: reductions
    logic              s2_vld_q, s2_vld_d;
    logic              s2_border_q, s2_border_d;
    mode_e             s2_mode_q, s2_mode_d;
    logic              s2_edge_q, s2_edge_d;
    logic [DATA_W-1:0] s2_raw_q, s2_raw_d;
    logic [SW-1:0]     s2_sum_q, s2_sum_d;
    logic [DATA_W-1:0] s2_min_q, s2_min_d;
    logic [DATA_W-1:0] s2_max_q, s2_max_d;

    // Stage 3: selected result; stage 4: output register
    logic              s3_vld_q, s3_vld_d;
    logic [DATA_W-1:0] s3_dat_q, s3_dat_d;
    logic              out_vld_q, out_vld_d;
    logic [DATA_W-1:0] out_dat_q, out_dat_d;

    // Sideband delay lines
    logic [3:0] vs_dly_q, vs_dly_d;
    logic [3:0] hs_dly_q, hs_dly_d;

    logic [SW-1:0]     sum_rnd;
    logic [PW-1:0]     div_prod;
    logic [DATA_W-1:0] mean_val;

    // A vsync edge in the same cycle as a pixel makes that pixel (0,0) of the new
    // frame with the freshly selected modes.
    always_comb begin
        vs_rise  = pre_img_vsync & ~vsync_q;
        accept   = pre_img_valid & (armed_q | vs_rise);
        col_cur  = vs_rise ? '0 : col_q;
        row_cur  = vs_rise ? '0 : row_q;
        mode_cur = vs_rise ? mode_e'(filt_mode) : mode_q;
        edge_cur = vs_rise ? edge_mode : edge_q;
    end

    always_comb begin
        vsync_d = pre_img_vsync;
        armed_d = armed_q | vs_rise;
        mode_d  = mode_cur;
        edge_d  = edge_cur;
        col_d   = col_cur;
        row_d   = row_cur;
        if (accept) begin
            if (col_cur == CW'(IMG_W - 1)) begin
                col_d = '0;
                // Row saturates on the last line: extra pixels keep overwriting it.
                if (row_cur != RW'(IMG_H - 1)) begin
                    row_d = row_cur + 1'b1;
                end
            end else begin
                col_d = col_cur + 1'b1;
            end
        end
    end

    assign lb1_rd = lb1_mem[col_cur];
    assign lb2_rd = lb2_mem[col_cur];

    // Contents are never reset; anything stale only feeds border pixels.
    always_ff @(posedge clk) begin
        if (accept) begin
            lb1_mem[col_cur] <= pre_img_data;
            lb2_mem[col_cur] <= lb1_rd;
        end
    end

    always_comb begin
        win_d = win_q;
        if (accept) begin
            for (int r = 0; r < 3; r++) begin
                win_d[r*3+0] = win_q[r*3+1];
                win_d[r*3+1] = win_q[r*3+2];
            end
            win_d[2] = lb2_rd;
            win_d[5] = lb1_rd;
            win_d[8] = pre_img_data;
        end
        s1_vld_d    = accept;
        s1_border_d = (row_cur < RW'(2)) || (col_cur < CW'(2));
        s1_mode_d   = mode_cur;
        s1_edge_d   = edge_cur;
    end

    always_comb begin
        s2_sum_d = '0;
        s2_min_d = win_q[0];
        s2_max_d = win_q[0];
        for (int i = 0; i < 9; i++) begin
            s2_sum_d = s2_sum_d + SW'(win_q[i]);
            if (win_q[i] < s2_min_d) s2_min_d = win_q[i];
            if (win_q[i] > s2_max_d) s2_max_d = win_q[i];
        end
        s2_vld_d    = s1_vld_q;
        s2_border_d = s1_border_q;
        s2_mode_d   = s1_mode_q;
        s2_edge_d   = s1_edge_q;
        s2_raw_d    = win_q[8];   // the pixel just accepted
    end

    // Rounded mean: floor((sum + 4) / 9) via reciprocal multiply; exact for all sums.
    always_comb begin
        sum_rnd  = s2_sum_q + SW'(4);
        div_prod = PW'(sum_rnd) * DIV9_MUL;
        mean_val = DATA_W'(div_prod >> SH);
    end

    always_comb begin
        s3_vld_d = s2_vld_q;
        if (s2_mode_q == MODE_BYPASS) begin
            s3_dat_d = s2_raw_q;
        end else if (s2_border_q) begin
            s3_dat_d = s2_edge_q ? '0 : s2_raw_q;
        end else begin
            case (s2_mode_q)
                MODE_MEAN: s3_dat_d = mean_val;
                MODE_MIN:  s3_dat_d = s2_min_q;
                default:   s3_dat_d = s2_max_q;
            endcase
        end
        out_vld_d = s3_vld_q;
        out_dat_d = s3_dat_q;
        vs_dly_d  = {vs_dly_q[2:0], pre_img_vsync};
        hs_dly_d  = {hs_dly_q[2:0], pre_img_hsync};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vsync_q     <= 1'b0;
            armed_q     <= 1'b0;
            col_q       <= '0;
            row_q       <= '0;
            mode_q      <= MODE_BYPASS;
            edge_q      <= 1'b0;
            win_q       <= '{default: '0};
            s1_vld_q    <= 1'b0;
            s1_border_q <= 1'b0;
            s1_mode_q   <= MODE_BYPASS;
            s1_edge_q   <= 1'b0;
            s2_vld_q    <= 1'b0;
            s2_border_q <= 1'b0;
            s2_mode_q   <= MODE_BYPASS;
            s2_edge_q   <= 1'b0;
            s2_raw_q    <= '0;
            s2_sum_q    <= '0;
            s2_min_q    <= '0;
            s2_max_q    <= '0;
            s3_vld_q    <= 1'b0;
            s3_dat_q    <= '0;
            out_vld_q   <= 1'b0;
            out_dat_q   <= '0;
            vs_dly_q    <= '0;
            hs_dly_q    <= '0;
        end else begin
            vsync_q     <= vsync_d;
            armed_q     <= armed_d;
            col_q       <= col_d;
            row_q       <= row_d;
            mode_q      <= mode_d;
            edge_q      <= edge_d;
            win_q       <= win_d;
            s1_vld_q    <= s1_vld_d;
            s1_border_q <= s1_border_d;
            s1_mode_q   <= s1_mode_d;
            s1_edge_q   <= s1_edge_d;
            s2_vld_q    <= s2_vld_d;
            s2_border_q <= s2_border_d;
            s2_mode_q   <= s2_mode_d;
            s2_edge_q   <= s2_edge_d;
            s2_raw_q    <= s2_raw_d;
            s2_sum_q    <= s2_sum_d;
            s2_min_q    <= s2_min_d;
            s2_max_q    <= s2_max_d;
            s3_vld_q    <= s3_vld_d;
            s3_dat_q    <= s3_dat_d;
            out_vld_q   <= out_vld_d;
            out_dat_q   <= out_dat_d;
            vs_dly_q    <= vs_dly_d;
            hs_dly_q    <= hs_dly_d;
        end
    end

    assign post_img_vsync = vs_dly_q[3];
    assign post_img_hsync = hs_dly_q[3];
    assign post_img_valid = out_vld_q;
    assign post_img_data  = out_dat_q;

endmodule

// File: tb/tb_avg_filter_param.sv
// Bench for avg_filter_param: 8x8 frames on an 8-bit instance against a frame-level model,
// plus a 12-bit 4x4 instance for saturation-free mean and sideband alignment.
module tb_avg_filter_param;

    localparam int W = 8;
    localparam int H = 8;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       pre_img_vsync, pre_img_hsync, pre_img_valid;
    logic [7:0] pre_img_data;
    logic [1:0] filt_mode;
    logic       edge_mode;
    logic       post_img_vsync, post_img_hsync, post_img_valid;
    logic [7:0] post_img_data;

    logic        b_vs, b_hs, b_vld;
    logic [11:0] b_dat;
    logic        b_ovs, b_ohs, b_ovld;
    logic [11:0] b_odat;

    always #5 clk = ~clk;

    avg_filter_param #(.DATA_W(8), .IMG_W(W), .IMG_H(H)) dut (
        .clk(clk), .rst_n(rst_n),
        .pre_img_vsync(pre_img_vsync), .pre_img_hsync(pre_img_hsync),
        .pre_img_valid(pre_img_valid), .pre_img_data(pre_img_data),
        .filt_mode(filt_mode), .edge_mode(edge_mode),
        .post_img_vsync(post_img_vsync), .post_img_hsync(post_img_hsync),
        .post_img_valid(post_img_valid), .post_img_data(post_img_data)
    );

    avg_filter_param #(.DATA_W(12), .IMG_W(4), .IMG_H(4)) dut12 (
        .clk(clk), .rst_n(rst_n),
        .pre_img_vsync(b_vs), .pre_img_hsync(b_hs),
        .pre_img_valid(b_vld), .pre_img_data(b_dat),
        .filt_mode(2'd1), .edge_mode(1'b0),
        .post_img_vsync(b_ovs), .post_img_hsync(b_ohs),
        .post_img_valid(b_ovld), .post_img_data(b_odat)
    );

    int checks = 0;
    int errors = 0;

    // Frame-level reference model state
    int         img [H][W];
    logic       m_prev_vs, m_armed, m_edge;
    logic [1:0] m_mode;
    int         m_row, m_col;
    logic       e_vld [4];
    logic       e_vs  [4];
    logic       e_hs  [4];
    int         e_dat [4];

    int fr [64];
    int cap [$];
    int gold [$];

    typedef struct {
        int         win [9];
        logic [1:0] mode;
        int         exp;
    } vec_t;
    vec_t vt [8];

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    task automatic model_clear();
        m_prev_vs = 1'b0;
        m_armed   = 1'b0;
        m_mode    = 2'd0;
        m_edge    = 1'b0;
        m_row     = 0;
        m_col     = 0;
        for (int i = 0; i < 4; i++) begin
            e_vld[i] = 1'b0; e_vs[i] = 1'b0; e_hs[i] = 1'b0; e_dat[i] = 0;
        end
    endtask

    // Expected output for the pixel at (r,c) of the current frame
    function automatic int ref_pix(int r, int c, int d);
        int s, mn, mx, v;
        if (m_mode == 2'd0) return d;
        if (r < 2 || c < 2) return m_edge ? 0 : d;
        s = 0; mn = 1 << 30; mx = -1;
        for (int dr = 0; dr < 3; dr++)
            for (int dc = 0; dc < 3; dc++) begin
                v = img[r-2+dr][c-2+dc];
                s += v;
                if (v < mn) mn = v;
                if (v > mx) mx = v;
            end
        case (m_mode)
            2'd1:    return (2 * s + 9) / 18;   // nearest integer to s/9 (never a tie)
            2'd2:    return mn;
            default: return mx;
        endcase
    endfunction

    // One clock cycle: check outputs due now, then drive this cycle's inputs.
    task automatic cyc(input logic v_s, input logic h_s, input logic vl, input int d,
                       input logic [1:0] f, input logic e);
        logic rise, acc;
        @(negedge clk);
        check("valid", post_img_valid, e_vld[3]);
        check("vsync", post_img_vsync, e_vs[3]);
        check("hsync", post_img_hsync, e_hs[3]);
        if (e_vld[3]) check("data", 32'(post_img_data), 32'(e_dat[3]));
        if (post_img_valid) cap.push_back(int'(post_img_data));
        for (int i = 3; i > 0; i--) begin
            e_vld[i] = e_vld[i-1]; e_vs[i] = e_vs[i-1]; e_hs[i] = e_hs[i-1]; e_dat[i] = e_dat[i-1];
        end
        pre_img_vsync = v_s;
        pre_img_hsync = h_s;
        pre_img_valid = vl;
        pre_img_data  = 8'(d);
        filt_mode     = f;
        edge_mode     = e;
        rise = v_s && !m_prev_vs;
        m_prev_vs = v_s;
        if (rise) begin
            m_armed = 1'b1; m_row = 0; m_col = 0; m_mode = f; m_edge = e;
        end
        acc = vl && m_armed;
        e_vld[0] = acc; e_vs[0] = v_s; e_hs[0] = h_s; e_dat[0] = 0;
        if (acc) begin
            img[m_row][m_col] = d & 255;
            e_dat[0] = ref_pix(m_row, m_col, d & 255);
            if (m_col == W - 1) begin
                m_col = 0;
                if (m_row < H - 1) m_row++;
            end else begin
                m_col++;
            end
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        pre_img_valid = 1'b0; pre_img_vsync = 1'b0; pre_img_hsync = 1'b0;
        @(negedge clk);
        check("rst_valid", post_img_valid, 1'b0);
        check("rst_vsync", post_img_vsync, 1'b0);
        check("rst_hsync", post_img_hsync, 1'b0);
        check("rst_data", 32'(post_img_data), 32'd0);
        rst_n = 1'b1;
        model_clear();
    endtask

    task automatic run_frame(input logic [1:0] fm, input logic em, input int gap_max,
                             input int mid_fm, input int rst_at);
        logic [1:0] cur;
        cur = fm;
        cap.delete();
        cyc(0, 0, 0, 0, fm, em);
        cyc(1, 0, 0, 0, fm, em);
        cyc(1, 0, 0, 0, fm, em);
        cyc(0, 0, 0, 0, fm, em);
        for (int p = 0; p < 64; p++) begin
            if (p == rst_at) begin
                do_reset();
                return;
            end
            if (p == 32 && mid_fm >= 0) cur = 2'(mid_fm);
            if (gap_max > 0)
                repeat ($urandom_range(gap_max, 0)) cyc(0, 1, 0, $urandom_range(255, 0), cur, em);
            cyc(0, 1, 1, fr[p], cur, em);
        end
        repeat (6) cyc(0, 0, 0, 0, cur, em);
    endtask

    task automatic rand_fill();
        for (int k = 0; k < 64; k++) fr[k] = $urandom_range(255, 0);
    endtask

    logic bv [40];
    logic bh [40];
    logic bl [40];

    initial begin
        vt[0].win = '{0, 0, 0, 0, 255, 0, 0, 0, 0};                 vt[0].mode = 2'd1; vt[0].exp = 28;
        vt[1].win = '{255, 255, 255, 255, 254, 255, 255, 255, 255}; vt[1].mode = 2'd1; vt[1].exp = 255;
        vt[2].win = '{5, 3, 9, 1, 7, 2, 8, 4, 6};                   vt[2].mode = 2'd2; vt[2].exp = 1;
        vt[3].win = '{5, 3, 9, 1, 7, 2, 8, 4, 6};                   vt[3].mode = 2'd3; vt[3].exp = 9;
        vt[4].win = '{0, 1, 2, 3, 4, 5, 6, 7, 8};                   vt[4].mode = 2'd1; vt[4].exp = 4;
        vt[5].win = '{4, 4, 5, 0, 0, 0, 0, 0, 0};                   vt[5].mode = 2'd1; vt[5].exp = 1;
        vt[6].win = '{5, 4, 5, 0, 0, 0, 0, 0, 0};                   vt[6].mode = 2'd1; vt[6].exp = 2;
        vt[7].win = '{200, 200, 200, 200, 0, 200, 200, 200, 200};   vt[7].mode = 2'd2; vt[7].exp = 0;

        rst_n = 1'b0;
        pre_img_vsync = 0; pre_img_hsync = 0; pre_img_valid = 0; pre_img_data = 0;
        filt_mode = 0; edge_mode = 0;
        b_vs = 0; b_hs = 0; b_vld = 0; b_dat = 0;
        model_clear();
        repeat (3) @(negedge clk);
        check("reset_valid", post_img_valid, 1'b0);
        check("reset_vsync", post_img_vsync, 1'b0);
        check("reset_hsync", post_img_hsync, 1'b0);
        check("reset_data", 32'(post_img_data), 32'd0);
        check("reset_valid12", b_ovld, 1'b0);
        rst_n = 1'b1;

        // Pixels before any vsync edge must not produce output
        repeat (4) cyc(0, 1, 1, 55, 2'd1, 1'b0);

        // Window vectors placed at rows 0..2, cols 0..2; result for input pixel (2,2)
        for (int i = 0; i < 8; i++) begin
            rand_fill();
            for (int r = 0; r < 3; r++)
                for (int c = 0; c < 3; c++) fr[r*8+c] = vt[i].win[r*3+c];
            run_frame(vt[i].mode, 1'b1, 0, -1, -1);
            if (cap.size() == 64) check($sformatf("table%0d", i), 32'(cap[18]), 32'(vt[i].exp));
            else check("table_count", 32'(cap.size()), 32'd64);
        end

        // Constant frame of 100, both border policies
        for (int k = 0; k < 64; k++) fr[k] = 100;
        run_frame(2'd1, 1'b0, 0, -1, -1);
        check("const_count", 32'(cap.size()), 32'd64);
        if (cap.size() == 64) begin
            check("const_border_raw", 32'(cap[0]), 32'd100);
            check("const_inner", 32'(cap[27]), 32'd100);
        end
        run_frame(2'd1, 1'b1, 0, -1, -1);
        if (cap.size() == 64) begin
            check("const_border_zero", 32'(cap[9]), 32'd0);
            check("const_inner_e1", 32'(cap[63]), 32'd100);
        end else check("const_count_e1", 32'(cap.size()), 32'd64);

        // Mode change mid-frame is ignored until the next vsync
        for (int k = 0; k < 64; k++) fr[k] = k;
        run_frame(2'd2, 1'b0, 0, 3, -1);
        if (cap.size() == 64) check("midchange_still_min", 32'(cap[63]), 32'd45);
        else check("midchange_count", 32'(cap.size()), 32'd64);
        run_frame(2'd3, 1'b0, 0, -1, -1);
        if (cap.size() == 64) check("next_frame_max", 32'(cap[63]), 32'd63);
        else check("nextframe_count", 32'(cap.size()), 32'd64);

        // Bypass ignores edge_mode
        rand_fill();
        run_frame(2'd0, 1'b1, 3, -1, -1);
        if (cap.size() == 64) check("bypass_border", 32'(cap[0]), 32'(fr[0]));
        else check("bypass_count", 32'(cap.size()), 32'd64);

        // Random frames in every mode with gaps, and gapless vs gapped identity
        for (int m = 0; m < 4; m++) begin
            rand_fill();
            run_frame(2'(m), 1'($urandom_range(1, 0)), 5, -1, -1);
        end
        rand_fill();
        run_frame(2'd1, 1'b0, 0, -1, -1);
        gold = cap;
        run_frame(2'd1, 1'b0, 5, -1, -1);
        check("gap_count", 32'(cap.size()), 32'(gold.size()));
        if (cap.size() == gold.size())
            for (int k = 0; k < cap.size(); k++) check("gap_identity", 32'(cap[k]), 32'(gold[k]));

        // Reset at pixel 30, unarmed pixels, then a clean frame
        rand_fill();
        run_frame(2'd1, 1'b0, 0, -1, 30);
        repeat (5) cyc(0, 1, 1, 77, 2'd1, 1'b0);
        rand_fill();
        run_frame(2'd3, 1'b0, 2, -1, -1);
        check("post_reset_count", 32'(cap.size()), 32'd64);

        // 12-bit instance: all 4095, mean, 4-cycle alignment of every sideband
        for (int k = 0; k < 40; k++) begin
            bv[k] = (k == 1 || k == 2);
            bl[k] = (k >= 5 && k < 21);
            bh[k] = bl[k];
        end
        for (int k = 0; k < 40; k++) begin
            @(negedge clk);
            check("w12_vsync", b_ovs, (k >= 4) ? bv[k-4] : 1'b0);
            check("w12_hsync", b_ohs, (k >= 4) ? bh[k-4] : 1'b0);
            check("w12_valid", b_ovld, (k >= 4) ? bl[k-4] : 1'b0);
            if (b_ovld) check("w12_data", 32'(b_odat), 32'd4095);
            b_vs = bv[k]; b_hs = bh[k]; b_vld = bl[k]; b_dat = 12'd4095;
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
